// File: rtl/bytewrite_ram_arbiter.sv
// Two-port round-robin front end for a single-port byte-write, no-change-mode BRAM.
// Commands are registered onto the RAM pins; read data returns two cycles after grant, tagged by port.
module bytewrite_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned COL_WIDTH  = 9,
    parameter int unsigned NB_COL     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          a_req,
    input  logic [NB_COL-1:0]             a_we,
    input  logic [ADDR_WIDTH-1:0]         a_addr,
    input  logic [NB_COL*COL_WIDTH-1:0]   a_di,
    output logic                          a_gnt,

    input  logic                          b_req,
    input  logic [NB_COL-1:0]             b_we,
    input  logic [ADDR_WIDTH-1:0]         b_addr,
    input  logic [NB_COL*COL_WIDTH-1:0]   b_di,
    output logic                          b_gnt,

    output logic [NB_COL-1:0]             ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [NB_COL*COL_WIDTH-1:0]   ram_di,
    input  logic [NB_COL*COL_WIDTH-1:0]   ram_do,

    output logic                          rd_valid,
    output logic                          rd_id,
    output logic [NB_COL*COL_WIDTH-1:0]   rd_data
);

    localparam int unsigned DataWidth = NB_COL * COL_WIDTH;

    typedef enum logic {
        PtrA = 1'b0,
        PtrB = 1'b1
    } rr_ptr_e;

    rr_ptr_e                 rr_q, rr_d;
    logic                    grant_a, grant_b;

    logic [NB_COL-1:0]       ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DataWidth-1:0]    ram_di_q, ram_di_d;

    // Stage 1 tracks the command on the RAM pins, stage 2 the cycle its data appears on ram_do.
    logic                    s1_rd_q, s1_rd_d;
    logic                    s1_id_q, s1_id_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_id_q, rd_id_d;

    // Grants are masked by rst_n so nothing is accepted while reset is asserted.
    always_comb begin
        grant_a = rst_n & a_req & (~b_req | (rr_q == PtrA));
        grant_b = rst_n & b_req & ~grant_a;
    end

    always_comb begin
        rr_d       = rr_q;
        ram_we_d   = '0;
        ram_addr_d = ram_addr_q;
        ram_di_d   = ram_di_q;
        s1_rd_d    = 1'b0;
        s1_id_d    = 1'b0;

        if (grant_a) begin
            rr_d       = PtrB;
            ram_we_d   = a_we;
            ram_addr_d = a_addr;
            ram_di_d   = a_di;
            s1_rd_d    = ~|a_we;
            s1_id_d    = 1'b0;
        end else if (grant_b) begin
            rr_d       = PtrA;
            ram_we_d   = b_we;
            ram_addr_d = b_addr;
            ram_di_d   = b_di;
            s1_rd_d    = ~|b_we;
            s1_id_d    = 1'b1;
        end

        rd_valid_d = s1_rd_q;
        rd_id_d    = s1_id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= PtrA;
            ram_we_q   <= '0;
            ram_addr_q <= '0;
            ram_di_q   <= '0;
            s1_rd_q    <= 1'b0;
            s1_id_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_di_q   <= ram_di_d;
            s1_rd_q    <= s1_rd_d;
            s1_id_q    <= s1_id_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
        end
    end

    assign a_gnt    = grant_a;
    assign b_gnt    = grant_b;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_di   = ram_di_q;
    assign rd_valid = rd_valid_q;
    assign rd_id    = rd_id_q;
    assign rd_data  = ram_do;

endmodule
